uart_tx_engine: RTL and testbench

UART transmit serializer: the transmit-side counterpart of the RX path. It pops words from the TX FIFO and drives the serial line with a start bit, 5..DATA_WIDTH data bits (LSB first), optional parity, and 1 or 2 stop bits. Bit timing comes from the shared oversampled baud tick, the same tick the RX path uses. It sits between the TX FIFO (combinational read data, pop on read enable) and the txd pad.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_bit_timer.sv | 28 ++
 rtl/uart_tx_engine.sv | 156 +++++++++++++++
 tb/tb_uart_tx_engine.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } tx_state_e;

   localparam int MIN_DATA_BITS      = 5;
   localparam int DEFAULT_OVERSAMPLE = 16;

   // Out-of-range frame lengths saturate to the nearest supported length.
   function automatic logic [3:0] clamp_data_bits(input logic [3:0] req, input int max_bits);
      if (int'(req) < MIN_DATA_BITS) begin
         return 4'(MIN_DATA_BITS);
      end
      if (int'(req) > max_bits) begin
         return 4'(max_bits);
      end
      return req;
   endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// rtl/uart_tx_bit_timer.sv - counts oversampled baud ticks and flags the end of each bit
module uart_tx_bit_timer #(
   parameter int OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic baud_tick,
   output logic bit_end
);

   localparam int               CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(OVERSAMPLE - 1);

   logic [CNT_W-1:0] tick_cnt;

   assign bit_end = baud_tick && (tick_cnt == LAST);

   // A clear wins over a coincident tick so every state starts a fresh bit period.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         tick_cnt <= '0;
      end else if (baud_tick) begin
         tick_cnt <= bit_end ? '0 : tick_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmit serializer between the TX FIFO and the txd pad
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  baud_tick,
   input  logic [DATA_WIDTH-1:0] fifo_read_data,
   input  logic                  fifo_empty,
   output logic                  fifo_read_en,
   input  logic                  tx_enable,
   input  logic [3:0]            cfg_data_bits,
   input  logic                  cfg_parity_en,
   input  logic                  cfg_parity_odd,
   input  logic                  cfg_stop_bits,
   input  logic                  break_req,
   output logic                  txd,
   output logic                  tx_busy,
   output logic                  tx_done
);

   tx_state_e             state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [3:0]            nbits_q, nbits_d;
   logic [3:0]            bit_cnt_q, bit_cnt_d;
   logic                  par_en_q, par_en_d;
   logic                  par_bit_q, par_bit_d;
   logic                  two_stop_q, two_stop_d;
   logic                  stop_cnt_q, stop_cnt_d;
   logic                  txd_d, done_d, bit_end, load;
   logic [3:0]            load_bits;
   logic [DATA_WIDTH-1:0] load_mask;

   assign load         = (state_q == IDLE) && !break_req && tx_enable && !fifo_empty && !rst;
   assign fifo_read_en = load;
   assign load_bits    = clamp_data_bits(cfg_data_bits, DATA_WIDTH);
   assign tx_busy      = (state_q != IDLE);

   always_comb begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
         load_mask[i] = (i < int'(load_bits));
      end
   end

   uart_tx_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_bit_timer (
      .clk       (clk),
      .rst       (rst),
      .clear     (state_d != state_q),
      .baud_tick (baud_tick),
      .bit_end   (bit_end)
   );

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      nbits_d    = nbits_q;
      bit_cnt_d  = bit_cnt_q;
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      two_stop_d = two_stop_q;
      stop_cnt_d = stop_cnt_q;
      done_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (break_req) begin
               state_d = BREAK;
            end else if (load) begin
               // Parity is fixed at load time so later cfg changes cannot touch this frame.
               state_d    = START;
               shift_d    = fifo_read_data;
               nbits_d    = load_bits;
               par_en_d   = cfg_parity_en;
               par_bit_d  = (^(fifo_read_data & load_mask)) ^ cfg_parity_odd;
               two_stop_d = cfg_stop_bits;
               stop_cnt_d = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_d   = DATA;
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == nbits_q - 4'd1) begin
                  state_d = par_en_q ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (two_stop_q && !stop_cnt_q) begin
                  stop_cnt_d = 1'b1;
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         BREAK: begin
            if (!break_req) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // The pad level follows the state being entered, so txd changes on the same edge as the state.
      txd_d = 1'b1;
      case (state_d)
         START, BREAK: txd_d = 1'b0;
         DATA:         txd_d = shift_d[0];
         PARITY:       txd_d = par_bit_q;
         default:      txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         nbits_q    <= '0;
         bit_cnt_q  <= '0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         two_stop_q <= 1'b0;
         stop_cnt_q <= 1'b0;
         txd        <= 1'b1;
         tx_done    <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         nbits_q    <= nbits_d;
         bit_cnt_q  <= bit_cnt_d;
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
         two_stop_q <= two_stop_d;
         stop_cnt_q <= stop_cnt_d;
         txd        <= txd_d;
         tx_done    <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - self-checking bench for uart_tx_engine
module tb_uart_tx_engine;

   localparam int DW = 8;
   localparam int OS = 16;

   logic          clk = 1'b0;
   logic          rst, baud_tick, fifo_empty, fifo_read_en, tx_enable;
   logic [DW-1:0] fifo_read_data;
   logic [3:0]    cfg_data_bits;
   logic          cfg_parity_en, cfg_parity_odd, cfg_stop_bits, break_req;
   logic          txd, tx_busy, tx_done;

   logic [DW-1:0] fifo_mem [0:255];
   int            wr_ptr = 0;
   int            rd_ptr = 0;
   bit            tick_rand = 1'b0;

   int            vectors = 0;
   int            miscompares = 0;
   int            pop_cnt = 0;
   int            done_cnt = 0;
   string         cur = "";
   string         exp_q[$];
   string         got_q[$];

   typedef struct {
      logic [DW-1:0] data;
      logic [3:0]    bits;
      bit            pen;
      bit            podd;
      bit            two;
      string         frame;
   } vec_t;

   vec_t tv [8];

   uart_tx_engine #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
      .clk            (clk),
      .rst            (rst),
      .baud_tick      (baud_tick),
      .fifo_read_data (fifo_read_data),
      .fifo_empty     (fifo_empty),
      .fifo_read_en   (fifo_read_en),
      .tx_enable      (tx_enable),
      .cfg_data_bits  (cfg_data_bits),
      .cfg_parity_en  (cfg_parity_en),
      .cfg_parity_odd (cfg_parity_odd),
      .cfg_stop_bits  (cfg_stop_bits),
      .break_req      (break_req),
      .txd            (txd),
      .tx_busy        (tx_busy),
      .tx_done        (tx_done)
   );

   always #5 clk = ~clk;

   assign fifo_read_data = fifo_mem[rd_ptr];
   assign fifo_empty     = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (fifo_read_en) rd_ptr <= rd_ptr + 1;
   end

   initial begin
      baud_tick = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         baud_tick = tick_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Expected frame as one character per bit period, built straight from the frame format rules.
   function automatic string frame_model(logic [DW-1:0] d, logic [3:0] req, bit pen, bit podd, bit two);
      int    n;
      int    ones;
      string s;
      n    = (req < 5) ? 5 : ((req > DW) ? DW : int'(req));
      ones = 0;
      s    = "0";
      for (int i = 0; i < n; i++) begin
         s    = {s, d[i] ? "1" : "0"};
         ones = ones + int'(d[i]);
      end
      if (pen) s = {s, (((ones % 2) == 1) != podd) ? "1" : "0"};
      s = {s, two ? "11" : "1"};
      return s;
   endfunction

   function automatic string expand(string s);
      string r = "";
      for (int i = 0; i < s.len(); i++)
         for (int k = 0; k < OS; k++) r = {r, s.substr(i, i)};
      return r;
   endfunction

   function automatic string decimate(string s);
      string r = "";
      for (int i = OS / 2; i < s.len(); i += OS) r = {r, s.substr(i, i)};
      return r;
   endfunction

   function automatic vec_t mk(logic [DW-1:0] d, logic [3:0] b, bit pen, bit podd, bit two, string f);
      vec_t v;
      v.data = d; v.bits = b; v.pen = pen; v.podd = podd; v.two = two; v.frame = f;
      return v;
   endfunction

   // txd sampled on every baud tick while busy; one string per completed frame.
   always @(negedge clk) begin
      if (fifo_read_en)
         exp_q.push_back(frame_model(fifo_read_data, cfg_data_bits, cfg_parity_en, cfg_parity_odd, cfg_stop_bits));
      if (fifo_read_en) pop_cnt++;
      if (!tx_busy) begin
         if (tx_done) begin
            got_q.push_back(cur);
            done_cnt++;
         end
         cur = "";
      end else if (baud_tick) begin
         cur = {cur, txd ? "1" : "0"};
      end
   end

   task automatic check_val(string name, int got, int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic check_str(string name, string g, string e);
      vectors++;
      if (g != expand(e)) begin
         miscompares++;
         $display("FAIL %s: got %0d samples [%s], required [%s]", name, g.len(), decimate(g), e);
      end
   endtask

   task automatic cyc(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(logic [DW-1:0] d);
      fifo_mem[wr_ptr] = d;
      wr_ptr++;
   endtask

   task automatic set_cfg(logic [3:0] b, bit pen, bit podd, bit two);
      cfg_data_bits = b; cfg_parity_en = pen; cfg_parity_odd = podd; cfg_stop_bits = two;
   endtask

   task automatic wait_busy(int budget);
      int k = 0;
      while (!tx_busy && k < budget) begin cyc(1); k++; end
      check_val("busy_within_budget", int'(k < budget), 1);
   endtask

   task automatic wait_idle(int budget);
      int k = 0;
      while (!(rd_ptr == wr_ptr && !tx_busy) && k < budget) begin cyc(1); k++; end
      check_val("idle_within_budget", int'(k < budget), 1);
      cyc(2);
   endtask

   task automatic check_frames();
      string g;
      while (got_q.size() > 0) begin
         g = got_q.pop_front();
         if (exp_q.size() == 0) check_val("unexpected_frame", 1, 0);
         else check_str("model_frame", g, exp_q.pop_front());
      end
      check_val("pending_frames", exp_q.size(), 0);
   endtask

   initial begin
      int    p0, d0, n, k, idle, dn, lows;
      string g;

      tv[0] = mk(8'h55, 4'd8,  0, 0, 0, "0101010101");
      tv[1] = mk(8'h41, 4'd7,  1, 0, 1, "01000001011");
      tv[2] = mk(8'hFF, 4'd8,  1, 1, 0, "01111111111");
      tv[3] = mk(8'h00, 4'd8,  1, 0, 0, "00000000001");
      tv[4] = mk(8'hE1, 4'd3,  1, 0, 0, "01000011");
      tv[5] = mk(8'hA3, 4'd12, 0, 0, 1, "01100010111");
      tv[6] = mk(8'h2D, 4'd6,  1, 1, 1, "0101101111");
      tv[7] = mk(8'h1F, 4'd0,  0, 0, 0, "0111111");

      rst = 1'b1; tx_enable = 1'b1; break_req = 1'b0;
      set_cfg(4'd8, 0, 0, 0);
      push(8'h96);
      cyc(3);
      check_val("reset_txd", int'(txd), 1);
      check_val("reset_busy", int'(tx_busy), 0);
      check_val("reset_done", int'(tx_done), 0);
      check_val("reset_pop", int'(fifo_read_en), 0);
      rst = 1'b0;
      wait_idle(2000);
      check_frames();

      for (int i = 0; i < 8; i++) begin
         set_cfg(tv[i].bits, tv[i].pen, tv[i].podd, tv[i].two);
         p0 = pop_cnt;
         push(tv[i].data);
         wait_busy(100);
         n = 0;
         while (!tx_done && n < 1000) begin cyc(1); n++; end
         check_val($sformatf("table_cycles_%0d", i), n, tv[i].frame.len() * OS);
         wait_idle(2000);
         check_val($sformatf("table_pops_%0d", i), pop_cnt - p0, 1);
         check_val($sformatf("table_frames_%0d", i), got_q.size(), 1);
         if (got_q.size() > 0) begin
            g = got_q.pop_front();
            check_str($sformatf("table_frame_%0d", i), g, tv[i].frame);
         end
         exp_q.delete();
      end

      set_cfg(4'd8, 0, 0, 0);
      p0 = pop_cnt;
      push(8'h01); push(8'h02); push(8'h03);
      wait_busy(100);
      idle = 0; dn = 0; k = 0;
      while (dn < 3 && k < 3000) begin
         @(negedge clk);
         if (!tx_busy) idle++;
         if (tx_done) dn++;
         k++;
      end
      cyc(1);
      check_val("b2b_done_pulses", dn, 3);
      check_val("b2b_idle_cycles", idle, 3);
      wait_idle(2000);
      check_val("b2b_pops", pop_cnt - p0, 3);
      check_frames();

      set_cfg(4'd8, 0, 0, 0);
      push(8'hA5); push(8'h3C);
      wait_busy(100);
      cyc(70);
      p0 = pop_cnt; d0 = done_cnt;
      rst = 1'b1;
      cyc(1);
      check_val("midrst_txd", int'(txd), 1);
      check_val("midrst_busy", int'(tx_busy), 0);
      check_val("midrst_pop", int'(fifo_read_en), 0);
      cyc(2);
      check_val("midrst_pop_cnt", pop_cnt - p0, 0);
      check_val("midrst_done_cnt", done_cnt - d0, 0);
      exp_q.delete();
      rst = 1'b0;
      wait_idle(2000);
      check_frames();

      set_cfg(4'd8, 1, 0, 0);
      push(8'h5B);
      wait_busy(100);
      cyc(60);
      set_cfg(4'd5, 0, 1, 1);
      wait_idle(2000);
      check_frames();

      set_cfg(4'd8, 0, 0, 0);
      p0 = pop_cnt; d0 = done_cnt;
      push(8'h11); push(8'h22);
      wait_busy(100);
      cyc(30);
      tx_enable = 1'b0;
      k = 0;
      while (tx_busy && k < 2000) begin cyc(1); k++; end
      cyc(100);
      check_val("txen_pops", pop_cnt - p0, 1);
      check_val("txen_dones", done_cnt - d0, 1);
      check_val("txen_fifo_left", wr_ptr - rd_ptr, 1);
      check_frames();
      tx_enable = 1'b1;
      wait_idle(2000);
      check_frames();

      tx_enable = 1'b0;
      cyc(2);
      p0 = pop_cnt;
      break_req = 1'b1; tx_enable = 1'b1;
      push(8'hC3);
      lows = 0;
      for (int i = 0; i < 501; i++) begin
         @(negedge clk);
         if (!txd) lows++;
      end
      #1;
      check_val("break_low_cycles", lows, 500);
      check_val("break_pops", pop_cnt - p0, 0);
      break_req = 1'b0;
      @(negedge clk);
      check_val("break_release_txd", int'(txd), 1);
      check_val("break_release_busy", int'(tx_busy), 0);
      check_val("break_release_pop", int'(fifo_read_en), 1);
      cyc(1);
      wait_idle(2000);
      check_val("break_no_done", int'(got_q.size() == 1), 1);
      check_frames();

      tick_rand = 1'b1;
      for (int i = 0; i < 16; i++) begin
         set_cfg(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         push(8'($urandom_range(0, 255)));
         cyc($urandom_range(0, 250));
         if ($urandom_range(0, 1) == 1)
            set_cfg(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      wait_idle(30000);
      check_frames();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

endmodule
